stv_rr_arbiter: RTL and testbench

STV_RR_ARBITER -- requirements
Module: stv_rr_arbiter

---
 rtl/stv_rr_arbiter_if.sv | 57 +++++
 rtl/stv_rr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_stv_rr_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/stv_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// stv_rr_arbiter_if
//
// Purpose : Groups the requester-side and downstream-side handshake of the
//           round-robin arbiter into one bundle.
//
// Signals :
//   req_valid    [NUM_REQ]              per-requester valid
//   req_data     [NUM_REQ][DATA_WIDTH]  per-requester payload, entry i = req i
//   req_ready    [NUM_REQ]              per-requester ready (grant & out_ready)
//   out_valid                           arbitrated output valid
//   out_data     [DATA_WIDTH]           payload of the granted requester
//   out_ready                           downstream ready
//   grant_onehot [NUM_REQ]              one-hot grant, zero when idle
//   grant_idx    [IDX_WIDTH]            binary grant index, zero when idle
//
// Modports: master = arbiter side, slave = requesters/downstream side.
// -----------------------------------------------------------------------------
interface stv_rr_arbiter_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8
);

   localparam int unsigned IDX_WIDTH = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]                 req_valid;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]                 req_ready;
   logic                               out_valid;
   logic [DATA_WIDTH-1:0]              out_data;
   logic                               out_ready;
   logic [NUM_REQ-1:0]                 grant_onehot;
   logic [IDX_WIDTH-1:0]               grant_idx;

   modport master (
      input  req_valid,
      input  req_data,
      input  out_ready,
      output req_ready,
      output out_valid,
      output out_data,
      output grant_onehot,
      output grant_idx
   );

   modport slave (
      output req_valid,
      output req_data,
      output out_ready,
      input  req_ready,
      input  out_valid,
      input  out_data,
      input  grant_onehot,
      input  grant_idx
   );

endinterface

// File: rtl/stv_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stv_rr_arbiter
//
// Purpose : Round-robin arbiter with a valid/ready output. The grant is
//           combinational (zero-cycle latency). Once a grant is offered and
//           downstream stalls, the arbiter locks onto that requester until
//           its transfer completes, so the offered payload never changes
//           under a stalled handshake.
//
// Ports   :
//   clk    in   sole clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   io_bus      stv_rr_arbiter_if.master (see interface header for signals)
//
// Parameters NUM_REQ / DATA_WIDTH must match those of the connected interface.
// -----------------------------------------------------------------------------
module stv_rr_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   stv_rr_arbiter_if.master  io_bus
);

   localparam int unsigned IDX_WIDTH = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ);

   typedef enum logic {
      StUnlocked,
      StLocked
   } state_e;

   // State
   state_e               r_state;
   logic [IDX_WIDTH-1:0] r_ptr;
   logic [IDX_WIDTH-1:0] r_lidx;

   // Next state
   state_e               w_state_nxt;
   logic [IDX_WIDTH-1:0] w_ptr_nxt;
   logic [IDX_WIDTH-1:0] w_lidx_nxt;

   // Arbitration
   logic [NUM_REQ-1:0]    w_mask_hi;
   logic [NUM_REQ-1:0]    w_req_hi;
   logic [NUM_REQ-1:0]    w_pick_hi;
   logic [NUM_REQ-1:0]    w_pick_lo;
   logic                  w_found_hi;
   logic                  w_found_lo;
   logic [NUM_REQ-1:0]    w_rr_oh;
   logic [NUM_REQ-1:0]    w_lock_oh;
   logic [NUM_REQ-1:0]    w_grant_oh;
   logic [IDX_WIDTH-1:0]  w_grant_idx;
   logic [DATA_WIDTH-1:0] w_out_data;
   logic                  w_out_valid;
   logic                  w_xfer;

   // ---------------------------------------------------------------------------
   // Round-robin pick: requesters at or above ptr take precedence; if none of
   // them is valid, the lowest valid requester below ptr wins. This realises
   // the circular scan ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_mask_hi = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_mask_hi[i] = (IDX_WIDTH'(i) >= r_ptr);
      end
   end

   assign w_req_hi = io_bus.req_valid & w_mask_hi;

   always_comb begin
      w_pick_hi  = '0;
      w_pick_lo  = '0;
      w_found_hi = 1'b0;
      w_found_lo = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (w_req_hi[i] && !w_found_hi) begin
            w_pick_hi[i] = 1'b1;
            w_found_hi   = 1'b1;
         end
         if (io_bus.req_valid[i] && !w_found_lo) begin
            w_pick_lo[i] = 1'b1;
            w_found_lo   = 1'b1;
         end
      end
      w_rr_oh = w_found_hi ? w_pick_hi : w_pick_lo;
   end

   // Locked grant is gated by the locked requester's own valid, so a requester
   // that illegally drops valid mid-lock never produces a phantom transfer.
   always_comb begin
      w_lock_oh = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_lock_oh[i] = io_bus.req_valid[i] && (IDX_WIDTH'(i) == r_lidx);
      end
   end

   assign w_grant_oh = (r_state == StLocked) ? w_lock_oh : w_rr_oh;

   // One-hot to binary encode and AND-OR payload mux; both collapse to zero
   // when there is no grant.
   always_comb begin
      w_grant_idx = '0;
      w_out_data  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (w_grant_oh[i]) begin
            w_grant_idx = w_grant_idx | IDX_WIDTH'(i);
            w_out_data  = w_out_data | io_bus.req_data[i];
         end
      end
   end

   assign w_out_valid = |w_grant_oh;
   assign w_xfer      = w_out_valid & io_bus.out_ready;

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign io_bus.out_valid    = w_out_valid;
   assign io_bus.out_data     = w_out_data;
   assign io_bus.grant_onehot = w_grant_oh;
   assign io_bus.grant_idx    = w_grant_idx;
   assign io_bus.req_ready    = w_grant_oh & {NUM_REQ{io_bus.out_ready}};

   // ---------------------------------------------------------------------------
   // Lock FSM and priority pointer, next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_lidx_nxt  = r_lidx;
      w_ptr_nxt   = r_ptr;

      unique case (r_state)
         StUnlocked: begin
            if (w_out_valid && !io_bus.out_ready) begin
               w_state_nxt = StLocked;
               w_lidx_nxt  = w_grant_idx;
            end
         end
         StLocked: begin
            // Leave on the locked transfer, or when the locked requester
            // withdrew its valid (no grant is then offered).
            if (!w_out_valid || io_bus.out_ready) begin
               w_state_nxt = StUnlocked;
            end
         end
         default: begin
            w_state_nxt = StUnlocked;
         end
      endcase

      if (w_xfer) begin
         if (w_grant_idx == IDX_WIDTH'(NUM_REQ - 1)) begin
            w_ptr_nxt = '0;
         end else begin
            w_ptr_nxt = w_grant_idx + IDX_WIDTH'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StUnlocked;
         r_ptr   <= '0;
         r_lidx  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_lidx  <= w_lidx_nxt;
      end
   end

endmodule

// File: tb/tb_stv_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stv_rr_arbiter
//
// Directed bench for stv_rr_arbiter (NUM_REQ = 4, DATA_WIDTH = 8), followed
// by a short random-traffic phase with a per-requester scoreboard.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_stv_rr_arbiter;

   localparam int unsigned NUM_REQ    = 4;
   localparam int unsigned DATA_WIDTH = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic ready_drv;

   int unsigned n_total;
   int unsigned n_pass;

   logic [DATA_WIDTH-1:0] pay [NUM_REQ];

   // Random-phase scoreboard
   logic [NUM_REQ-1:0]    rv;
   logic [DATA_WIDTH-1:0] rd [NUM_REQ];
   int unsigned           waits [NUM_REQ];
   int unsigned           issued;
   int unsigned           served;
   int unsigned           g;
   logic [DATA_WIDTH-1:0] seq;
   logic                  rr;

   stv_rr_arbiter_if #(
      .NUM_REQ    (NUM_REQ),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_if ();

   stv_rr_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (u_if.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive(input logic [NUM_REQ-1:0] v, input logic r);
      u_if.req_valid = v;
      u_if.out_ready = r;
      ready_drv      = r;
      for (int i = 0; i < NUM_REQ; i++) u_if.req_data[i] = pay[i];
   endtask

   // Expected outputs for a grant (or none) to exp_idx under the driven ready.
   task automatic check_out(input string tag, input logic exp_valid, input int unsigned exp_idx);
      logic [NUM_REQ-1:0]    oh;
      logic [DATA_WIDTH-1:0] d;
      int unsigned           idx;
      oh  = exp_valid ? (NUM_REQ'(1) << exp_idx) : '0;
      d   = exp_valid ? pay[exp_idx] : '0;
      idx = exp_valid ? exp_idx : 0;
      check({tag, ".valid"}, 32'(u_if.out_valid), 32'(exp_valid));
      check({tag, ".onehot"}, 32'(u_if.grant_onehot), 32'(oh));
      check({tag, ".idx"}, 32'(u_if.grant_idx), idx);
      check({tag, ".data"}, 32'(u_if.out_data), 32'(d));
      check({tag, ".ready"}, 32'(u_if.req_ready), 32'(oh & {NUM_REQ{ready_drv}}));
   endtask

   // One cycle: drive, sample, advance to 1 unit past the next rising edge.
   task automatic step(input string tag, input logic [NUM_REQ-1:0] v, input logic r,
                       input logic exp_valid, input int unsigned exp_idx);
      drive(v, r);
      #1;
      check_out(tag, exp_valid, exp_idx);
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      pay[0]  = 8'h3C;
      pay[1]  = 8'hA5;
      pay[2]  = 8'h5A;
      pay[3]  = 8'hC3;

      // Reset: idle outputs, then combinational grant from ptr = 0.
      rst_n = 1'b0;
      drive(4'b0000, 1'b0);
      #2;
      check_out("rst_idle", 1'b0, 0);
      drive(4'b0110, 1'b0);
      #1;
      check_out("rst_comb", 1'b1, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Scenario 1: all requesting, always ready -> strict rotation.
      for (int k = 0; k < 8; k++) begin
         step($sformatf("s1_%0d", k), 4'b1111, 1'b1, 1'b1, k % 4);
      end

      // Scenario 2: ptr = 1, 4'b1001 with stall -> held on 3, one transfer.
      step("s2_pre", 4'b0001, 1'b1, 1'b1, 0);
      step("s2_c1", 4'b1001, 1'b0, 1'b1, 3);
      step("s2_c2", 4'b1001, 1'b0, 1'b1, 3);
      step("s2_c3", 4'b1001, 1'b0, 1'b1, 3);
      step("s2_c4", 4'b1001, 1'b1, 1'b1, 3);
      step("s2_after", 4'b0011, 1'b1, 1'b1, 0);

      // Lock holds against a lower-ptr requester appearing (ptr = 1 here).
      step("lk_a", 4'b0100, 1'b0, 1'b1, 2);
      step("lk_b", 4'b0111, 1'b0, 1'b1, 2);
      step("lk_c", 4'b0111, 1'b1, 1'b1, 2);

      // Scenario 3: transfer from 3 wraps ptr to 0.
      step("s3_a", 4'b1000, 1'b1, 1'b1, 3);
      step("s3_b", 4'b0110, 1'b1, 1'b1, 1);
      step("s3_c", 4'b0011, 1'b1, 1'b1, 0);

      // Scenario 4: lock on 2 with ptr = 2, then async reset mid-cycle.
      step("s4_pre", 4'b0010, 1'b1, 1'b1, 1);
      step("s4_lock", 4'b0100, 1'b0, 1'b1, 2);
      drive(4'b0110, 1'b0);
      #1;
      check_out("s4_locked", 1'b1, 2);
      #1;
      rst_n = 1'b0;
      #1;
      check_out("s4_rst", 1'b1, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step("s4_first", 4'b0110, 1'b1, 1'b1, 1);

      // Scenario 5: idle cycles leave ptr (= 2) alone.
      for (int k = 0; k < 5; k++) begin
         step($sformatf("s5_%0d", k), 4'b0000, 1'(k % 2), 1'b0, 0);
      end
      step("s5_ptr", 4'b1111, 1'b1, 1'b1, 2);

      // Locked requester drops valid: unlock, ptr (= 3) unchanged.
      step("pv_lock", 4'b0010, 1'b0, 1'b1, 1);
      drive(4'b0000, 1'b0);
      @(posedge clk);
      #1;
      step("pv_after", 4'b0101, 1'b1, 1'b1, 0);

      // Scenario 6: random traffic, valid held until transferred.
      rv     = '0;
      issued = 0;
      served = 0;
      seq    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rd[i]    = '0;
         waits[i] = 0;
      end
      for (int cyc = 0; cyc < 300; cyc++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!rv[i] && ($urandom_range(0, 2) == 0)) begin
               rv[i]    = 1'b1;
               rd[i]    = seq;
               seq      = seq + 8'd1;
               waits[i] = 0;
               issued++;
            end
         end
         rr             = 1'($urandom_range(0, 1));
         u_if.req_valid = rv;
         u_if.out_ready = rr;
         for (int i = 0; i < NUM_REQ; i++) u_if.req_data[i] = rd[i];
         #1;
         check("r_onehot0", 32'($onehot0(u_if.grant_onehot)), 32'd1);
         check("r_ovalid", 32'(u_if.out_valid), 32'(|rv));
         if (u_if.out_valid) begin
            g = 32'(u_if.grant_idx);
            check("r_gvalid", 32'(rv[g]), 32'd1);
            check("r_goh", 32'(u_if.grant_onehot), 32'(NUM_REQ'(1) << g));
            check("r_data", 32'(u_if.out_data), 32'(rd[g]));
            if (rr) begin
               served++;
               rv[g] = 1'b0;
               for (int j = 0; j < NUM_REQ; j++) begin
                  if (rv[j]) begin
                     waits[j]++;
                     check($sformatf("r_wait%0d", j), 32'(waits[j] <= NUM_REQ), 32'd1);
                  end
               end
            end
         end
         @(posedge clk);
         #1;
      end
      check("r_conserve", served + 32'($countones(rv)), issued);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
